// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a {Z,N,H,C} flag register and two-cycle wide ADD/INC/DEC.
// Define ALU_SEQ_DAA_EN to make opcode F a BCD adjust; otherwise F passes A through.
module alu_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [OPCODE_WIDTH-1:0] i_control,
  input  logic                    i_wide,
  input  logic [2*DATA_WIDTH-1:0] i_data_A,
  input  logic [2*DATA_WIDTH-1:0] i_data_B,
  input  logic                    i_flags_load,
  input  logic [7:0]              i_flags,
  output logic [2*DATA_WIDTH-1:0] o_data,
  output logic                    o_valid,
  output logic [7:0]              o_flags
);

  localparam int W = DATA_WIDTH;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WIDE_HI = 1'b1;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADC = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SBC = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_CP  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_INC = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_DEC = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_RL  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_RR  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLA = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRA = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRL = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_DAA = OPCODE_WIDTH'(15);

  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FH = 1;
  localparam int FC = 0;

  localparam logic [W:0] ONE_X = (W+1)'(1);

  logic [0:0]     state_q, state_d;
  logic [3:0]     flags_q, flags_d;
  logic [2*W-1:0] data_q, data_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   a_hi_q, a_hi_d;
  logic [W-1:0]   b_hi_q, b_hi_d;
  logic           cy_q, cy_d;
  logic           wadd_q, wadd_d;
  logic           wdec_q, wdec_d;

  logic           accept;
  logic           wide_op;
  logic [W-1:0]   a_n, b_n;
  logic           cin;
  logic [W:0]     add_ext, sub_ext;
  logic [W-1:0]   res_n;
  logic [3:0]     fl_n;
  logic [W:0]     wlo_ext, whi_ext;
  logic           whi_h;
  logic           unused_flag_bits;

  assign unused_flag_bits = ^i_flags[3:0];

  assign o_ready = (state_q == ST_IDLE) && !i_rst;
  assign accept  = i_valid && o_ready;
  assign wide_op = i_wide && ((i_control == OP_ADD) || (i_control == OP_INC) ||
                              (i_control == OP_DEC));

  assign a_n = i_data_A[W-1:0];
  assign b_n = i_data_B[W-1:0];

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_flags = {flags_q, 4'b0000};

`ifdef ALU_SEQ_DAA_EN
  logic [W-1:0] daa_v;
  logic         daa_c;

  // Game Boy style decimal adjust: direction chosen by N, corrections by H and C.
  always_comb begin
    daa_v = a_n;
    daa_c = flags_q[FC];
    if (!flags_q[FN]) begin
      if (flags_q[FC] || (a_n > W'(8'h99))) begin
        daa_v = daa_v + W'(8'h60);
        daa_c = 1'b1;
      end
      if (flags_q[FH] || (a_n[3:0] > 4'd9)) begin
        daa_v = daa_v + W'(8'h06);
      end
    end else begin
      if (flags_q[FC]) begin
        daa_v = daa_v - W'(8'h60);
      end
      if (flags_q[FH]) begin
        daa_v = daa_v - W'(8'h06);
      end
    end
  end
`endif

  always_comb begin
    cin     = ((i_control == OP_ADC) || (i_control == OP_SBC)) ? flags_q[FC] : 1'b0;
    add_ext = {1'b0, a_n} + {1'b0, b_n} + {{W{1'b0}}, cin};
    sub_ext = {1'b0, a_n} - {1'b0, b_n} - {{W{1'b0}}, cin};
    res_n   = a_n;
    fl_n    = flags_q;
    // Nibble carry/borrow recovered from operand and result bit 4.
    case (i_control)
      OP_ADD, OP_ADC: begin
        res_n = add_ext[W-1:0];
        fl_n  = {res_n == '0, 1'b0, a_n[4] ^ b_n[4] ^ add_ext[4], add_ext[W]};
      end
      OP_SUB, OP_SBC: begin
        res_n = sub_ext[W-1:0];
        fl_n  = {res_n == '0, 1'b1, a_n[4] ^ b_n[4] ^ sub_ext[4], sub_ext[W]};
      end
      OP_CP: begin
        res_n = a_n;
        fl_n  = {sub_ext[W-1:0] == '0, 1'b1, a_n[4] ^ b_n[4] ^ sub_ext[4], sub_ext[W]};
      end
      OP_AND: begin
        res_n = a_n & b_n;
        fl_n  = {res_n == '0, 1'b0, 1'b1, 1'b0};
      end
      OP_XOR: begin
        res_n = a_n ^ b_n;
        fl_n  = {res_n == '0, 3'b000};
      end
      OP_OR: begin
        res_n = a_n | b_n;
        fl_n  = {res_n == '0, 3'b000};
      end
      OP_INC: begin
        res_n = a_n + W'(1);
        fl_n  = {res_n == '0, 1'b0, a_n[3:0] == 4'hF, flags_q[FC]};
      end
      OP_DEC: begin
        res_n = a_n - W'(1);
        fl_n  = {res_n == '0, 1'b1, a_n[3:0] == 4'h0, flags_q[FC]};
      end
      OP_RL: begin
        res_n = {a_n[W-2:0], flags_q[FC]};
        fl_n  = {res_n == '0, 2'b00, a_n[W-1]};
      end
      OP_RR: begin
        res_n = {flags_q[FC], a_n[W-1:1]};
        fl_n  = {res_n == '0, 2'b00, a_n[0]};
      end
      OP_SLA: begin
        res_n = {a_n[W-2:0], 1'b0};
        fl_n  = {res_n == '0, 2'b00, a_n[W-1]};
      end
      OP_SRA: begin
        res_n = {a_n[W-1], a_n[W-1:1]};
        fl_n  = {res_n == '0, 2'b00, a_n[0]};
      end
      OP_SRL: begin
        res_n = {1'b0, a_n[W-1:1]};
        fl_n  = {res_n == '0, 2'b00, a_n[0]};
      end
      OP_DAA: begin
`ifdef ALU_SEQ_DAA_EN
        res_n = daa_v;
        fl_n  = {daa_v == '0, flags_q[FN], 1'b0, daa_c};
`else
        res_n = a_n;
        fl_n  = flags_q;
`endif
      end
      default: begin
        res_n = a_n;
        fl_n  = flags_q;
      end
    endcase
  end

  // Wide ops split into a low half at accept and a high half in WIDE_HI.
  always_comb begin
    if (i_control == OP_INC) begin
      wlo_ext = {1'b0, a_n} + ONE_X;
    end else if (i_control == OP_DEC) begin
      wlo_ext = {1'b0, a_n} - ONE_X;
    end else begin
      wlo_ext = {1'b0, a_n} + {1'b0, b_n};
    end
    if (wdec_q) begin
      whi_ext = {1'b0, a_hi_q} - {{W{1'b0}}, cy_q};
    end else begin
      whi_ext = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{W{1'b0}}, cy_q};
    end
    whi_h = a_hi_q[4] ^ b_hi_q[4] ^ whi_ext[4];
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    data_d  = data_q;
    valid_d = 1'b0;
    lo_d    = lo_q;
    a_hi_d  = a_hi_q;
    b_hi_d  = b_hi_q;
    cy_d    = cy_q;
    wadd_d  = wadd_q;
    wdec_d  = wdec_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && wide_op) begin
          lo_d    = wlo_ext[W-1:0];
          cy_d    = wlo_ext[W];
          a_hi_d  = i_data_A[2*W-1:W];
          b_hi_d  = (i_control == OP_ADD) ? i_data_B[2*W-1:W] : '0;
          wadd_d  = (i_control == OP_ADD);
          wdec_d  = (i_control == OP_DEC);
          state_d = ST_WIDE_HI;
        end else if (accept) begin
          data_d  = {{W{1'b0}}, res_n};
          flags_d = fl_n;
          valid_d = 1'b1;
        end else if (i_flags_load) begin
          flags_d = i_flags[7:4];
        end
      end
      default: begin
        // Requests and flag loads arriving here are dropped while busy.
        data_d = {whi_ext[W-1:0], lo_q};
        if (wadd_q) begin
          flags_d = {flags_q[FZ], 1'b0, whi_h, whi_ext[W]};
        end
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      flags_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lo_q    <= '0;
      a_hi_q  <= '0;
      b_hi_q  <= '0;
      cy_q    <= 1'b0;
      wadd_q  <= 1'b0;
      wdec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lo_q    <= lo_d;
      a_hi_q  <= a_hi_d;
      b_hi_q  <= b_hi_d;
      cy_q    <= cy_d;
      wadd_q  <= wadd_d;
      wdec_q  <= wdec_d;
    end
  end

endmodule
